// File: rtl/fdc_disk_bridge.sv
// fdc_disk_bridge
//   Disk-side back end for the nec765 FDC core. Decodes the core's command
//   word into read / write / seek requests for the host sector service,
//   streams sector bytes between that service and the core's sector FIFOs,
//   and reports ready / done / error plus a rotating READ ID sector number.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   disk_sr[31:0]         command word from the FDC core
//   disk_cr[31:0]         status word to the FDC core
//   disk_data_in/clkin    read byte and write strobe into the FDC input FIFO
//   disk_data_out/clkout  write byte and pop strobe of the FDC output FIFO
//   host_present[1:0]     disk inserted, per drive
//   host_req/op/drive/chs host command (op: 0 read, 1 write, 2 seek)
//   host_ack/host_err     single-cycle host response and its error flag
//   host_rd_*             read byte stream from the host (valid/ready)
//   host_wr_*             write byte stream to the host (valid/ready)
module fdc_disk_bridge #(
    parameter int          SECTOR_BYTES      = 512,
    parameter logic [7:0]  FIRST_SECTOR      = 8'hC1,
    parameter int          SECTORS_PER_TRACK = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disk_sr,
    output logic [31:0] disk_cr,
    output logic [7:0]  disk_data_in,
    output logic        disk_data_clkin,
    input  logic [7:0]  disk_data_out,
    output logic        disk_data_clkout,
    input  logic [1:0]  host_present,
    output logic        host_req,
    output logic [1:0]  host_op,
    output logic        host_drive,
    output logic [15:0] host_chs,
    input  logic        host_ack,
    input  logic        host_err,
    input  logic [7:0]  host_rd_data,
    input  logic        host_rd_valid,
    output logic        host_rd_ready,
    output logic [7:0]  host_wr_data,
    output logic        host_wr_valid,
    input  logic        host_wr_ready
);

    typedef enum logic [2:0] {
        IDLE, REQ, RD_XFER, WR_POP, WR_WAIT, WR_SEND, WR_ACK, DONE
    } state_t;

    localparam logic [1:0] OP_RD = 2'd0;
    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_SK = 2'd2;
    localparam logic [9:0] LAST_BYTE = 10'(SECTOR_BYTES - 1);
    localparam logic [7:0] LAST_ID   = FIRST_SECTOR + 8'(SECTORS_PER_TRACK - 1);

    state_t     state;
    logic [9:0] count;
    logic       wait_cnt;
    logic       cur_drive;
    logic       done;
    logic       err;
    logic [7:0] id;
    logic       tog_prev;

    logic       new_req;
    logic [1:0] new_op;
    logic       new_drive;
    logic       req_live;
    logic       seek_done;
    logic       present;

    // Bits of the command word this block does not act on.
    logic unused_sr;
    assign unused_sr = ^{disk_sr[31:26], disk_sr[23], disk_sr[19], disk_sr[16]};

    // Request decode: write beats read beats seek; lower drive wins a tie.
    always_comb begin
        new_req   = 1'b1;
        new_op    = OP_RD;
        new_drive = 1'b0;
        if (disk_sr[20] || disk_sr[21]) begin
            new_op    = OP_WR;
            new_drive = ~disk_sr[20];
        end else if (disk_sr[17] || disk_sr[18]) begin
            new_op    = OP_RD;
            new_drive = ~disk_sr[17];
        end else if (disk_sr[24] || disk_sr[25]) begin
            new_op    = OP_SK;
            new_drive = ~disk_sr[24];
        end else begin
            new_req   = 1'b0;
        end
    end

    // The request bit that started the current operation; the FDC drops it
    // both to acknowledge done and to abort (FDC reset).
    always_comb begin
        case (host_op)
            OP_WR:   req_live = host_drive ? disk_sr[21] : disk_sr[20];
            OP_SK:   req_live = host_drive ? disk_sr[25] : disk_sr[24];
            default: req_live = host_drive ? disk_sr[18] : disk_sr[17];
        endcase
    end

    assign seek_done = (state == REQ) && (host_op == OP_SK) && host_ack && req_live;
    assign present   = host_present[cur_drive];
    assign disk_cr   = {present ? id : 8'h00, 18'b0, present, done, err, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            count            <= '0;
            wait_cnt         <= 1'b0;
            cur_drive        <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            host_req         <= 1'b0;
            host_op          <= OP_RD;
            host_drive       <= 1'b0;
            host_chs         <= '0;
            host_rd_ready    <= 1'b0;
            host_wr_data     <= '0;
            host_wr_valid    <= 1'b0;
            disk_data_in     <= '0;
            disk_data_clkin  <= 1'b0;
            disk_data_clkout <= 1'b0;
        end else begin
            disk_data_clkin  <= 1'b0;
            disk_data_clkout <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_req) begin
                        host_req   <= 1'b1;
                        host_op    <= new_op;
                        host_drive <= new_drive;
                        cur_drive  <= new_drive;
                        host_chs   <= {disk_sr[15], disk_sr[14:8], disk_sr[7:0]};
                        count      <= '0;
                        if (new_op == OP_WR) begin
                            disk_data_clkout <= 1'b1;
                            state            <= WR_POP;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (!req_live) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    if (!req_live) begin
                        // Aborted by the FDC: quietly return without a done.
                        host_req      <= 1'b0;
                        host_wr_valid <= 1'b0;
                        host_rd_ready <= 1'b0;
                        count         <= '0;
                        wait_cnt      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        case (state)
                            REQ: begin
                                if (host_ack) begin
                                    host_req <= 1'b0;
                                    if (host_op == OP_RD && !host_err) begin
                                        host_rd_ready <= 1'b1;
                                        state         <= RD_XFER;
                                    end else begin
                                        done  <= 1'b1;
                                        err   <= host_err;
                                        state <= DONE;
                                    end
                                end
                            end
                            RD_XFER: begin
                                // The FDC input FIFO holds a whole sector, so
                                // every offered byte is taken at once.
                                if (host_rd_valid) begin
                                    disk_data_in    <= host_rd_data;
                                    disk_data_clkin <= 1'b1;
                                    if (count == LAST_BYTE) begin
                                        host_rd_ready <= 1'b0;
                                        done          <= 1'b1;
                                        err           <= 1'b0;
                                        state         <= DONE;
                                    end else begin
                                        count <= count + 10'd1;
                                    end
                                end
                            end
                            WR_POP: begin
                                wait_cnt <= 1'b0;
                                state    <= WR_WAIT;
                            end
                            WR_WAIT: begin
                                // Two cycles for the popped byte to settle on
                                // the FIFO output before it is captured.
                                if (!wait_cnt) begin
                                    wait_cnt <= 1'b1;
                                end else begin
                                    host_wr_data  <= disk_data_out;
                                    host_wr_valid <= 1'b1;
                                    state         <= WR_SEND;
                                end
                            end
                            WR_SEND: begin
                                if (host_wr_ready) begin
                                    host_wr_valid <= 1'b0;
                                    if (count == LAST_BYTE) begin
                                        state <= WR_ACK;
                                    end else begin
                                        count            <= count + 10'd1;
                                        disk_data_clkout <= 1'b1;
                                        state            <= WR_POP;
                                    end
                                end
                            end
                            WR_ACK: begin
                                if (host_ack) begin
                                    host_req <= 1'b0;
                                    done     <= 1'b1;
                                    err      <= host_err;
                                    state    <= DONE;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // READ ID rotation; a completing seek returns to the first sector and
    // takes precedence over a toggle in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id       <= FIRST_SECTOR;
            tog_prev <= 1'b0;
        end else begin
            tog_prev <= disk_sr[22];
            if (seek_done) begin
                id <= FIRST_SECTOR;
            end else if (disk_sr[22] != tog_prev) begin
                id <= (id == LAST_ID) ? FIRST_SECTOR : id + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fdc_disk_bridge.sv
module tb_fdc_disk_bridge;
    localparam int         SB  = 512;
    localparam logic [7:0] FS  = 8'hC1;
    localparam int         SPT = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] disk_sr;
    logic [31:0] disk_cr;
    logic [7:0]  disk_data_in;
    logic        disk_data_clkin;
    logic [7:0]  disk_data_out;
    logic        disk_data_clkout;
    logic [1:0]  host_present;
    logic        host_req;
    logic [1:0]  host_op;
    logic        host_drive;
    logic [15:0] host_chs;
    logic        host_ack;
    logic        host_err;
    logic [7:0]  host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [7:0]  host_wr_data;
    logic        host_wr_valid;
    logic        host_wr_ready;

    int   n_cmp = 0;
    int   n_err = 0;
    int   id_m;
    logic tog;

    always #5 clk = ~clk;

    fdc_disk_bridge #(.SECTOR_BYTES(SB), .FIRST_SECTOR(FS), .SECTORS_PER_TRACK(SPT)) dut (
        .clk(clk), .rst_n(rst_n), .disk_sr(disk_sr), .disk_cr(disk_cr),
        .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
        .host_present(host_present), .host_req(host_req), .host_op(host_op),
        .host_drive(host_drive), .host_chs(host_chs), .host_ack(host_ack),
        .host_err(host_err), .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .host_rd_ready(host_rd_ready), .host_wr_data(host_wr_data),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready)
    );

    // Command word write that keeps the current state of the next-ID toggle.
    task automatic set_sr(input logic [31:0] v);
        disk_sr     = v;
        disk_sr[22] = tog;
    endtask

    function automatic int next_id(input int cur);
        return FS + ((cur - FS + 1) % SPT);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; tog = 1'b0; disk_sr = '0; host_present = 2'b11;
        host_ack = 0; host_err = 0; host_rd_data = 0; host_rd_valid = 0;
        host_wr_ready = 0; disk_data_out = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (disk_cr !== 32'hC100_0020) begin n_err++; $display("FAIL reset_cr: got %h want %h", disk_cr, 32'hC100_0020); end
        n_cmp++; if ({host_req, host_rd_ready, host_wr_valid, disk_data_clkin, disk_data_clkout} !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 00000", {host_req, host_rd_ready, host_wr_valid, disk_data_clkin, disk_data_clkout}); end
        n_cmp++; if ({host_chs, host_op, host_wr_data, disk_data_in} !== 34'b0) begin n_err++; $display("FAIL reset_data: got %h want 0", {host_chs, host_op, host_wr_data, disk_data_in}); end
        rst_n = 1'b1;
        @(negedge clk);
        id_m = FS;
    endtask

    // Read one sector on drive 0; abort_at > 0 drops the request after that many bytes.
    task automatic do_read(input logic [6:0] cyl, input logic [7:0] sec, input int abort_at,
                           input bit pattern, input string tag);
        logic [31:0] v;
        logic [7:0]  expq[$];
        logic [7:0]  b;
        int sent, got, cyc, limit, strays;
        bit done_seen;
        v = '0; v[17] = 1'b1; v[14:8] = cyl; v[7:0] = sec;
        set_sr(v);
        @(negedge clk);
        n_cmp++; if ({host_req, host_op, host_drive, host_chs} !== {1'b1, 2'd0, 1'b0, 1'b0, cyl, sec}) begin n_err++; $display("FAIL %s_cmd: got req=%b op=%0d drv=%b chs=%h want req=1 op=0 drv=0 chs=%h", tag, host_req, host_op, host_drive, host_chs, {1'b0, cyl, sec}); end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n_cmp++; if ({host_req, host_rd_ready} !== 2'b10) begin n_err++; $display("FAIL %s_wait: got req/ready=%b want 10", tag, {host_req, host_rd_ready}); end
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        n_cmp++; if ({host_req, host_rd_ready, disk_cr[4]} !== 3'b010) begin n_err++; $display("FAIL %s_ack: got req/ready/done=%b want 010", tag, {host_req, host_rd_ready, disk_cr[4]}); end
        limit = (abort_at > 0) ? abort_at : SB;
        sent = 0; got = 0; cyc = 0; done_seen = 0;
        while (!done_seen && cyc < 5000) begin
            if (disk_data_clkin) begin
                b = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                n_cmp++; if (disk_data_in !== b) begin n_err++; $display("FAIL %s_byte%0d: got %h want %h", tag, got, disk_data_in, b); end
                got++;
            end
            if (disk_cr[4]) begin
                done_seen = 1;
                n_cmp++; if ({disk_data_clkin, disk_cr[3], got == SB} !== 3'b101) begin n_err++; $display("FAIL %s_done_edge: got strobe=%b err=%b bytes=%0d want strobe=1 err=0 bytes=%0d", tag, disk_data_clkin, disk_cr[3], got, SB); end
            end
            if (abort_at > 0 && got == abort_at) break;
            host_rd_valid = 1'b0;
            if (!done_seen && sent < limit && host_rd_ready && $urandom_range(0, 3) != 0) begin
                host_rd_data  = pattern ? 8'(sent) : 8'($urandom);
                host_rd_valid = 1'b1;
                expq.push_back(host_rd_data);
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        host_rd_valid = 1'b0;
        if (abort_at > 0) begin
            set_sr('0);
            @(negedge clk);
            n_cmp++; if ({host_req, host_rd_ready, disk_cr[4]} !== 3'b000) begin n_err++; $display("FAIL %s_abort: got req/ready/done=%b want 000 (bytes=%0d)", tag, {host_req, host_rd_ready, disk_cr[4]}, got); end
            strays = 0;
            repeat (20) begin
                host_rd_valid = 1'b1; host_rd_data = 8'($urandom);
                @(negedge clk);
                if (disk_data_clkin || disk_cr[4] || host_req) strays++;
            end
            host_rd_valid = 1'b0;
            n_cmp++; if (strays !== 0) begin n_err++; $display("FAIL %s_abort_idle: got %0d active cycles want 0", tag, strays); end
        end else begin
            n_cmp++; if (!done_seen || got != SB) begin n_err++; $display("FAIL %s_complete: got done=%b bytes=%0d want done=1 bytes=%0d", tag, done_seen, got, SB); end
            repeat (3) @(negedge clk);
            n_cmp++; if ({disk_cr[31:24], disk_cr[5:3], disk_data_clkin} !== {8'(id_m), 3'b110, 1'b0}) begin n_err++; $display("FAIL %s_hold: got cr=%h clkin=%b want id=%h bits5:3=110", tag, disk_cr, disk_data_clkin, 8'(id_m)); end
            set_sr('0);
            @(negedge clk);
            n_cmp++; if (disk_cr[4:3] !== 2'b00) begin n_err++; $display("FAIL %s_done_fall: got %b want 00", tag, disk_cr[4:3]); end
            @(negedge clk);
        end
    endtask

    task automatic test_read_err();
        logic [31:0] v;
        int strobes;
        v = '0; v[18] = 1'b1; v[14:8] = 7'd9; v[7:0] = 8'hC5;
        set_sr(v);
        @(negedge clk);
        n_cmp++; if ({host_req, host_op, host_drive} !== 4'b1001) begin n_err++; $display("FAIL rderr_cmd: got req/op/drv=%b want 1001", {host_req, host_op, host_drive}); end
        host_ack = 1'b1; host_err = 1'b1;
        @(negedge clk);
        host_ack = 1'b0; host_err = 1'b0;
        n_cmp++; if ({disk_cr[4:3], host_req, host_rd_ready} !== 4'b1100) begin n_err++; $display("FAIL rderr_done: got done/err/req/ready=%b want 1100", {disk_cr[4:3], host_req, host_rd_ready}); end
        strobes = 0;
        repeat (10) begin
            host_rd_valid = 1'b1; host_rd_data = 8'($urandom);
            @(negedge clk);
            if (disk_data_clkin) strobes++;
        end
        host_rd_valid = 1'b0;
        n_cmp++; if (strobes !== 0) begin n_err++; $display("FAIL rderr_no_bytes: got %0d strobes want 0", strobes); end
        set_sr('0);
        @(negedge clk);
        n_cmp++; if (disk_cr[4:3] !== 2'b00) begin n_err++; $display("FAIL rderr_clear: got %b want 00", disk_cr[4:3]); end
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0]  fifo [SB];
        logic [31:0] v;
        int pops, recv, cyc, first_pop, first_valid, extra;
        for (int i = 0; i < SB; i++) fifo[i] = 8'($urandom);
        fifo[0] = 8'hA5; fifo[1] = 8'h5A;
        v = '0; v[20] = 1'b1; v[15] = 1'b1; v[14:8] = 7'd5; v[7:0] = 8'hC3;
        set_sr(v);
        @(negedge clk);
        n_cmp++; if ({host_req, host_op, host_drive, host_chs} !== {1'b1, 2'd1, 1'b0, 16'h85C3}) begin n_err++; $display("FAIL wr_cmd: got req=%b op=%0d drv=%b chs=%h want 1 1 0 85c3", host_req, host_op, host_drive, host_chs); end
        pops = 0; recv = 0; cyc = 0; first_pop = -1; first_valid = -1;
        while (recv < SB && cyc < 8000) begin
            if (disk_data_clkout) begin
                if (first_pop < 0) first_pop = cyc;
                if (pops < SB) disk_data_out = fifo[pops];
                pops++;
            end
            host_wr_ready = ($urandom_range(0, 2) != 0);
            if (host_wr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (host_wr_ready) begin
                    n_cmp++; if (host_wr_data !== fifo[recv]) begin n_err++; $display("FAIL wr_byte%0d: got %h want %h", recv, host_wr_data, fifo[recv]); end
                    recv++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        host_wr_ready = 1'b0;
        n_cmp++; if (first_valid - first_pop !== 3) begin n_err++; $display("FAIL wr_latency: got %0d cycles want 3", first_valid - first_pop); end
        extra = 0;
        repeat (5) begin
            if (disk_data_clkout || host_wr_valid || disk_cr[4] || !host_req) extra++;
            @(negedge clk);
        end
        n_cmp++; if (pops !== SB || recv !== SB || extra !== 0) begin n_err++; $display("FAIL wr_count: got pops=%0d sent=%0d odd=%0d want %0d %0d 0", pops, recv, extra, SB, SB); end
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        n_cmp++; if ({disk_cr[4:3], host_req} !== 3'b100) begin n_err++; $display("FAIL wr_done: got done/err/req=%b want 100", {disk_cr[4:3], host_req}); end
        set_sr('0);
        @(negedge clk);
        n_cmp++; if (disk_cr[4] !== 1'b0) begin n_err++; $display("FAIL wr_done_fall: got %b want 0", disk_cr[4]); end
        @(negedge clk);
    endtask

    task automatic test_ack_ignored();
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({disk_cr[4:3], host_req} !== 3'b000) begin n_err++; $display("FAIL ack_idle: got %b want 000", {disk_cr[4:3], host_req}); end
    endtask

    task automatic test_seek();
        logic [31:0] v;
        repeat (2) begin
            tog = ~tog; disk_sr[22] = tog;
            @(negedge clk);
            id_m = next_id(id_m);
        end
        n_cmp++; if (disk_cr[31:24] !== 8'(id_m)) begin n_err++; $display("FAIL seek_pre_id: got %h want %h", disk_cr[31:24], 8'(id_m)); end
        v = '0; v[25] = 1'b1; v[14:8] = 7'd20;
        set_sr(v);
        @(negedge clk);
        n_cmp++; if ({host_req, host_op, host_drive, host_chs} !== {1'b1, 2'd2, 1'b1, 16'h1400}) begin n_err++; $display("FAIL seek_cmd: got req=%b op=%0d drv=%b chs=%h want 1 2 1 1400", host_req, host_op, host_drive, host_chs); end
        tog = ~tog; disk_sr[22] = tog; host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
        id_m = FS;
        n_cmp++; if (disk_cr !== 32'hC100_0030) begin n_err++; $display("FAIL seek_done: got %h want %h", disk_cr, 32'hC100_0030); end
        set_sr('0);
        @(negedge clk);
        n_cmp++; if (disk_cr !== 32'hC100_0020) begin n_err++; $display("FAIL seek_clear: got %h want %h", disk_cr, 32'hC100_0020); end
        host_present = 2'b01;
        #1;
        n_cmp++; if (disk_cr !== 32'h0) begin n_err++; $display("FAIL seek_drive1_absent: got %h want 0", disk_cr); end
        host_present = 2'b11;
        @(negedge clk);
    endtask

    task automatic test_id_rotation();
        for (int i = 0; i < 10; i++) begin
            tog = ~tog; disk_sr[22] = tog;
            @(negedge clk);
            id_m = next_id(id_m);
            n_cmp++; if (disk_cr[31:24] !== 8'(id_m)) begin n_err++; $display("FAIL id_step%0d: got %h want %h", i, disk_cr[31:24], 8'(id_m)); end
        end
        host_present = 2'b00;
        tog = ~tog; disk_sr[22] = tog;
        @(negedge clk);
        id_m = next_id(id_m);
        n_cmp++; if ({disk_cr[31:24], disk_cr[5]} !== 9'b0) begin n_err++; $display("FAIL id_absent: got id=%h ready=%b want 0 0", disk_cr[31:24], disk_cr[5]); end
        host_present = 2'b11;
        #1;
        n_cmp++; if (disk_cr !== {8'(id_m), 24'h000020}) begin n_err++; $display("FAIL id_present_again: got %h want %h", disk_cr, {8'(id_m), 24'h000020}); end
        @(negedge clk);
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] v;
        v = '0; v[21] = 1'b1; v[14:8] = 7'd2; v[7:0] = 8'hC4;
        set_sr(v);
        host_wr_ready = 1'b1;
        repeat (30) begin
            if (disk_data_clkout) disk_data_out = 8'($urandom);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({host_req, host_wr_valid, host_rd_ready, disk_data_clkin, disk_data_clkout} !== 5'b0) begin n_err++; $display("FAIL rst_async_strobes: got %b want 00000", {host_req, host_wr_valid, host_rd_ready, disk_data_clkin, disk_data_clkout}); end
        n_cmp++; if ({host_chs, host_op, host_drive, host_wr_data, disk_data_in} !== 35'b0) begin n_err++; $display("FAIL rst_async_data: got %h want 0", {host_chs, host_op, host_drive, host_wr_data, disk_data_in}); end
        n_cmp++; if (disk_cr !== 32'hC100_0020) begin n_err++; $display("FAIL rst_async_cr: got %h want %h", disk_cr, 32'hC100_0020); end
        host_wr_ready = 1'b0; tog = 1'b0; disk_sr = '0; id_m = FS;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({disk_cr, host_req} !== {32'hC100_0020, 1'b0}) begin n_err++; $display("FAIL rst_release: got cr=%h req=%b want c1000020 0", disk_cr, host_req); end
    endtask

    initial begin
        test_reset();
        do_read(7'd3, 8'hC2, 0, 1'b1, "read");
        test_read_err();
        test_write();
        test_ack_ignored();
        test_seek();
        test_id_rotation();
        do_read(7'd7, 8'hC6, 100, 1'b0, "abort");
        do_read(7'd1, 8'hC9, 0, 1'b0, "b2b");
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
